// File: rtl/act_pkg.sv
// Shared definitions for the activation pipeline: mode encodings and counter width.
package act_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS   = 2'b00,
        ACT_RELU     = 2'b01,
        ACT_LEAKY    = 2'b10,
        ACT_RELU_ALT = 2'b11
    } act_mode_t;

    localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/act_sat.sv
// Per-lane rounding and saturation of a wide signed accumulator to a signed
// Q(W_INT_W).(DATA_W-W_INT_W) output sample.
module act_sat #(
    parameter int DATA_W  = 16,
    parameter int W_INT_W = 4,
    parameter int INT_EXT = 10,
    parameter int ROUND   = 1,
    localparam int ACC_W  = 2*DATA_W+INT_EXT
) (
    input  logic [ACC_W-1:0]  x,
    output logic [DATA_W-1:0] y,
    output logic              sat
);

    localparam int SH = DATA_W-W_INT_W;

    // One extra bit of headroom so the rounding add can never wrap.
    localparam logic signed [ACC_W:0] BIAS =
        (ROUND != 0) ? ((ACC_W+1)'(1) <<< (SH-1)) : '0;
    localparam logic signed [ACC_W:0] MAXV =
        {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV =
        {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] q;

    always_comb begin
        ext    = {x[ACC_W-1], x};
        biased = ext + BIAS;
        q      = biased >>> SH;
        sat    = 1'b0;
        y      = q[DATA_W-1:0];
        if (q > MAXV) begin
            y   = {1'b0, {(DATA_W-1){1'b1}}};
            sat = 1'b1;
        end else if (q < MINV) begin
            y   = {1'b1, {(DATA_W-1){1'b0}}};
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/act_pipe.sv
// Two-stage multi-lane activation pipeline: activation on accept, then
// round/saturate into the output register, with a sticky saturation counter.
module act_pipe
    import act_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int W_INT_W = 4,
    parameter int INT_EXT = 10,
    parameter int LANES   = 4,
    parameter int ROUND   = 1,
    parameter int LEAK_SH = 3,
    localparam int ACC_W  = 2*DATA_W+INT_EXT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*ACC_W-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [SAT_CNT_W-1:0]      sat_cnt,
    input  logic                      sat_clr
);

    logic                        en;
    act_mode_t                   in_mode;
    logic signed [ACC_W-1:0]     lane;
    logic signed [ACC_W-1:0]     act_lane;
    logic [LANES*ACC_W-1:0]      act_data;
    logic                        s1_valid;
    logic [LANES*ACC_W-1:0]      s1_data;
    logic [LANES*DATA_W-1:0]     sat_data;
    logic [LANES-1:0]            sat_flags;
    logic [LANES-1:0]            s2_sat;
    logic [SAT_CNT_W:0]          sat_sum;
    logic [SAT_CNT_W:0]          cnt_sum;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign in_mode  = act_mode_t'(mode);

    // Activation is applied as the beat is captured, so mode travels with it.
    always_comb begin
        act_data = '0;
        lane     = '0;
        act_lane = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane = in_data[l*ACC_W +: ACC_W];
            case (in_mode)
                ACT_BYPASS: act_lane = lane;
                ACT_LEAKY:  act_lane = lane[ACC_W-1] ? (lane >>> LEAK_SH) : lane;
                default:    act_lane = lane[ACC_W-1] ? '0 : lane;
            endcase
            act_data[l*ACC_W +: ACC_W] = act_lane;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_data  <= act_data;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_sat #(
            .DATA_W (DATA_W),
            .W_INT_W(W_INT_W),
            .INT_EXT(INT_EXT),
            .ROUND  (ROUND)
        ) u_sat (
            .x  (s1_data[g*ACC_W +: ACC_W]),
            .y  (sat_data[g*DATA_W +: DATA_W]),
            .sat(sat_flags[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            s2_sat    <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            out_data  <= sat_data;
            s2_sat    <= sat_flags;
        end
    end

    // Saturation events are counted as the beat leaves the output register.
    always_comb begin
        sat_sum = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            sat_sum = sat_sum + {{SAT_CNT_W{1'b0}}, s2_sat[l]};
        end
        cnt_sum = {1'b0, sat_cnt} + sat_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (en && out_valid) begin
            sat_cnt <= cnt_sum[SAT_CNT_W] ? '1 : cnt_sum[SAT_CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_act_pipe.sv
// Self-checking bench for act_pipe: directed vectors plus an arithmetic
// reference model and scoreboard evaluated every cycle.
module tb_act_pipe;

    localparam int DATA_W  = 16;
    localparam int W_INT_W = 4;
    localparam int INT_EXT = 10;
    localparam int LANES   = 4;
    localparam int ROUND   = 1;
    localparam int LEAK_SH = 3;
    localparam int ACC_W   = 2*DATA_W+INT_EXT;
    localparam int OUT_W   = LANES*DATA_W;
    localparam int SH      = DATA_W-W_INT_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [1:0]               mode;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*ACC_W-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic [15:0]              sat_cnt;
    logic                     sat_clr;

    always #5 clk = ~clk;

    act_pipe #(
        .DATA_W (DATA_W),
        .W_INT_W(W_INT_W),
        .INT_EXT(INT_EXT),
        .LANES  (LANES),
        .ROUND  (ROUND),
        .LEAK_SH(LEAK_SH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sat_cnt  (sat_cnt),
        .sat_clr  (sat_clr)
    );

    typedef struct {
        logic [OUT_W-1:0] data;
        int               nsat;
    } exp_t;

    exp_t             expq[$];
    int               checks = 0;
    int               errors = 0;
    int               model_cnt = 0;
    bit               stall_prev = 0;
    logic [OUT_W-1:0] stall_data = '0;
    bit               acc_last = 0;
    int               delivered = 0;
    int               ready_low = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic exp_t model_beat(input logic [LANES*ACC_W-1:0] d, input logic [1:0] m);
        exp_t e;
        e.data = '0;
        e.nsat = 0;
        for (int i = 0; i < LANES; i++) begin
            logic signed [ACC_W-1:0] raw;
            longint x, a, q;
            logic [DATA_W-1:0] y;
            raw = d[i*ACC_W +: ACC_W];
            x = raw;
            if (m == 2'b00)      a = x;
            else if (m == 2'b10) a = (x < 0) ? floor_div(x, longint'(2**LEAK_SH)) : x;
            else                 a = (x < 0) ? 0 : x;
            if (ROUND != 0) a = a + (longint'(1) << (SH-1));
            q = floor_div(a, longint'(1) << SH);
            if (q > longint'(2**(DATA_W-1)) - 1) begin
                y = {1'b0, {(DATA_W-1){1'b1}}};
                e.nsat++;
            end else if (q < -longint'(2**(DATA_W-1))) begin
                y = {1'b1, {(DATA_W-1){1'b0}}};
                e.nsat++;
            end else begin
                y = DATA_W'(q);
            end
            e.data[i*DATA_W +: DATA_W] = y;
        end
        return e;
    endfunction

    task automatic sb_step();
        int n;
        exp_t e;
        acc_last = 0;
        if (rst) begin
            expq.delete();
            model_cnt  = 0;
            stall_prev = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_sat_cnt", sat_cnt, 0);
            return;
        end
        chk("sat_cnt", sat_cnt, model_cnt);
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (stall_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, stall_data);
        end
        stall_prev = 0;
        n = 0;
        if (out_valid) begin
            chk("beat_pending", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                chk("out_data", out_data, expq[0].data);
                if (out_ready) begin
                    e = expq.pop_front();
                    n = e.nsat;
                    delivered++;
                end else begin
                    stall_prev = 1;
                    stall_data = out_data;
                end
            end
        end
        if (sat_clr)                   model_cnt = 0;
        else if (model_cnt + n > 65535) model_cnt = 65535;
        else                           model_cnt = model_cnt + n;
        if (!in_ready) ready_low++;
        if (in_valid && in_ready) begin
            expq.push_back(model_beat(in_data, mode));
            acc_last = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [1:0] m, input longint l0, input longint l1,
                            input longint l2, input longint l3);
        mode    = m;
        in_data = {ACC_W'(l3), ACC_W'(l2), ACC_W'(l1), ACC_W'(l0)};
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && expq.size() > 0; i++) tick();
        chk("drain_empty", expq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   idx;
        int   d0;
        longint big;
        big = longint'(1) << 40;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        mode = 2'b00; in_data = '0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_sat_cnt", sat_cnt, 0);
        chk("reset_out_data", out_data, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // ReLU with rounding boundary values
        set_beat(2'b01, 'h1000, 'h800, 'h7FF, -4096);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("relu_latency_1cyc", out_valid, 0);
        tick();
        chk("relu_valid", out_valid, 1);
        chk("relu_data", out_data, 64'h0000_0000_0001_0001);
        tick();
        chk("relu_sat_cnt", sat_cnt, 0);

        // Bypass with saturation at both rails and just-inside values
        set_beat(2'b00, big, -big, longint'('h7FFF000), -longint'('h8000000));
        e = model_beat(in_data, mode);
        chk("model_bypass_pin", e.data, 64'h8000_7FFF_8000_7FFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("bypass_valid", out_valid, 1);
        chk("bypass_data", out_data, 64'h8000_7FFF_8000_7FFF);
        tick();
        chk("bypass_sat_cnt", sat_cnt, 2);

        // Leaky ReLU
        set_beat(2'b10, -32768, 'h3000, 0, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("leaky_data", out_data, 64'h0000_0000_0003_FFFF);
        tick();
        chk("leaky_sat_cnt", sat_cnt, 2);

        // Mode 11 behaves as ReLU
        set_beat(2'b11, -5, 'h1800, 0, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mode3_data", out_data, 64'h0000_0000_0002_0000);
        tick();

        // 8-beat stream with a downstream stall on cycles 3-5
        idx = 0;
        d0 = delivered;
        ready_low = 0;
        for (int c = 0; c < 60 && (idx < 8 || expq.size() > 0); c++) begin
            out_ready = !(c >= 3 && c <= 5);
            if (idx < 8) begin
                mode = 2'(idx % 3);
                for (int j = 0; j < LANES; j++)
                    in_data[j*ACC_W +: ACC_W] = ACC_W'((longint'(idx) - 4) * 'h1234 + longint'(j) * 'h555);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (acc_last) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_accepted", idx, 8);
        chk("stream_delivered", delivered - d0, 8);
        chk("stream_ready_dropped", ready_low > 0, 1);
        drain();

        // Saturate every lane long enough to pin the counter, then clear
        set_beat(2'b00, big, big, -big, -big);
        in_valid = 1'b1;
        for (int i = 0; i < 16400; i++) tick();
        chk("sat_sticky", sat_cnt, 16'hFFFF);
        chk("clr_beat_leaving", out_valid, 1);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("sat_clr_priority", sat_cnt, 0);
        in_valid = 1'b0;
        drain();

        // Reset with two beats in flight
        set_beat(2'b01, 'h5000, 'h6000, 0, 0);
        in_valid = 1'b1;
        tick();
        set_beat(2'b01, 'h7000, 'h8000, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", out_valid, 0);
        chk("rst_async_in_ready", in_ready, 1);
        chk("rst_async_out_data", out_data, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale_beat", out_valid, 0);
        end
        set_beat(2'b01, 'h1000, 'h800, 'h7FF, -4096);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 64'h0000_0000_0001_0001);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
